// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder with a two-entry (main + skid) valid/ready buffer.
// Decode happens on the input side and lands registered one cycle later.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] T_I = 3'd0;
  localparam logic [2:0] T_S = 3'd1;
  localparam logic [2:0] T_B = 3'd2;
  localparam logic [2:0] T_U = 3'd3;
  localparam logic [2:0] T_J = 3'd4;
  localparam logic [2:0] T_Z = 3'd5;
  localparam logic [2:0] T_R = 3'd6;
  localparam logic [2:0] T_X = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      ty;
    logic            ill;
    logic [XLEN-1:0] pc;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_e;

  state_e           state_q, state_d;
  ent_t             main_q, main_d;
  ent_t             skid_q, skid_d;
  ent_t             dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;

  logic [6:0]  opc;
  logic [31:0] ins;
  logic [31:0] imm32;
  logic        op_i, op_s, op_b, op_u;
  logic        op_j, op_z, op_r;
  logic        acc, drn;

  assign ins = in_instr;
  assign opc = in_instr[6:0];

  assign op_i = (opc == 7'h13) || (opc == 7'h03)
             || (opc == 7'h67) || (opc == 7'h0F)
             || (RV64 && opc == 7'h1B)
             || (opc == 7'h73 && !ins[14]);
  assign op_s = (opc == 7'h23);
  assign op_b = (opc == 7'h63);
  assign op_u = (opc == 7'h37) || (opc == 7'h17);
  assign op_j = (opc == 7'h6F);
  assign op_z = (opc == 7'h73) && ins[14];
  assign op_r = (opc == 7'h33)
             || (RV64 && opc == 7'h3B);

  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    imm32  = '0;
    unique case (1'b1)
      op_i: begin
        dec.ty = T_I;
        imm32  = {{20{ins[31]}}, ins[31:20]};
      end
      op_s: begin
        dec.ty = T_S;
        imm32  = {{20{ins[31]}}, ins[31:25],
                  ins[11:7]};
      end
      op_b: begin
        dec.ty = T_B;
        imm32  = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
      end
      op_u: begin
        dec.ty = T_U;
        imm32  = {ins[31:12], 12'b0};
      end
      op_j: begin
        dec.ty = T_J;
        imm32  = {{11{ins[31]}}, ins[31],
                  ins[19:12], ins[20],
                  ins[30:21], 1'b0};
      end
      op_z: begin
        dec.ty = T_Z;
        imm32  = {27'b0, ins[19:15]};
      end
      op_r: begin
        dec.ty = T_R;
      end
      default: begin
        dec.ty  = T_X;
        dec.ill = 1'b1;
      end
    endcase
    // zimm is zero-extended, everything else sign-extends from bit 31
    if (op_z) dec.imm = XLEN'(imm32);
    else      dec.imm = XLEN'($signed(imm32));
  end

  assign acc = in_valid && rdy_q;
  assign drn = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      if (acc && dec.ill && cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_d = dec;
          end else if (acc) begin
            skid_d  = dec;
            state_d = TWO;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drn) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_imm     = main_q.imm;
  assign out_type    = main_q.ty;
  assign out_illegal = main_q.ill;
  assign out_pc      = main_q.pc;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV64/2-bit-counter instance and an
// RV32/default instance share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64, out_pc64;
  logic [2:0]  out_ty64;
  logic [1:0]  cnt64;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_pc32;
  logic [2:0]  out_ty32;
  logic [15:0] cnt32;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_type(out_ty64),
    .out_illegal(out_ill64), .out_pc(out_pc64),
    .illegal_cnt(cnt64)
  );

  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_type(out_ty32),
    .out_illegal(out_ill32), .out_pc(out_pc32),
    .illegal_cnt(cnt32)
  );

  typedef struct {
    logic [63:0] imm64;
    logic [2:0]  ty64;
    logic [63:0] imm32;
    logic [2:0]  ty32;
    logic [63:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 0;
  int   mcnt64 = 0;
  int   mcnt32 = 0;
  int   qn;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] ins,
                                  input bit x64,
                                  output logic [63:0] imm,
                                  output logic [2:0] ty);
    longint v;
    v = 0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h0F: ty = 0;
      7'h1B: ty = x64 ? 3'd0 : 3'd7;
      7'h23: ty = 1;
      7'h63: ty = 2;
      7'h37, 7'h17: ty = 3;
      7'h6F: ty = 4;
      7'h33: ty = 6;
      7'h3B: ty = x64 ? 3'd6 : 3'd7;
      7'h73: ty = ins[14] ? 3'd5 : 3'd0;
      default: ty = 7;
    endcase
    case (ty)
      0: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      1: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      2: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3: begin
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= (longint'(1) << 32);
      end
      4: begin
        v = longint'(ins[31]) * (longint'(1) << 20)
          + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048
          + longint'(ins[30:21]) * 2;
        if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
      end
      5: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    imm = 64'(v);
  endfunction

  // model bookkeeping on the active edge (pre-edge values)
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mcnt64 = 0;
      mcnt32 = 0;
      started = 0;
    end else begin
      started = 1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid64 && out_ready && exp_q.size() > 0)
          void'(exp_q.pop_front());
        if (in_valid && in_ready64) begin
          exp_t e;
          logic [63:0] t;
          ref_dec(in_instr, 1'b1, e.imm64, e.ty64);
          ref_dec(in_instr, 1'b0, t, e.ty32);
          e.imm32 = {32'b0, t[31:0]};
          e.pc = in_pc;
          exp_q.push_back(e);
          if (e.ty64 == 7 && mcnt64 < 3) mcnt64++;
          if (e.ty32 == 7 && mcnt32 < 65535) mcnt32++;
        end
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n && started) begin
      qn = exp_q.size();
      chk("in_ready64", in_ready64, qn < 2);
      chk("in_ready32", in_ready32, qn < 2);
      chk("out_valid64", out_valid64, qn > 0);
      chk("out_valid32", out_valid32, qn > 0);
      if (qn > 0) begin
        chk("imm64", out_imm64, exp_q[0].imm64);
        chk("type64", out_ty64, exp_q[0].ty64);
        chk("ill64", out_ill64, exp_q[0].ty64 == 7);
        chk("pc64", out_pc64, exp_q[0].pc);
        chk("imm32", out_imm32, exp_q[0].imm32);
        chk("type32", out_ty32, exp_q[0].ty32);
        chk("ill32", out_ill32, exp_q[0].ty32 == 7);
        chk("pc32", out_pc32, {32'b0, exp_q[0].pc[31:0]});
      end
      chk("cnt64", cnt64, mcnt64);
      chk("cnt32", cnt32, mcnt32);
    end
  end

  task automatic send(input logic [31:0] ins,
                      input logic [63:0] pc,
                      input bit ordy);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    n = 0;
    while (!in_ready64) begin
      if (n == 40) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic idle(input int cyc);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, {in_ready64, in_ready32}, 0);
    chk({tag, "_vld"}, {out_valid64, out_valid32}, 0);
    chk({tag, "_imm64"}, out_imm64, 0);
    chk({tag, "_imm32"}, out_imm32, 0);
    chk({tag, "_ty"}, {out_ty64, out_ty32}, 0);
    chk({tag, "_ill"}, {out_ill64, out_ill32}, 0);
    chk({tag, "_pc"}, out_pc64 | out_pc32, 0);
    chk({tag, "_cnt"}, {cnt64, cnt32}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [6:0] ops [14] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h1B,
                           7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                           7'h33, 7'h3B, 7'h73, 7'h7F};
  logic [1:0] saved64;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    send(32'hFFF00093, 64'h100, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("addi_imm32", out_imm32, 64'hFFFF_FFFF);
    chk("addi_type", out_ty32, 0);
    chk("addi_ill", out_ill32, 0);

    send(32'h800000EF, 64'h104, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("jal_imm64", out_imm64, 64'hFFFF_FFFF_FFF0_0000);
    chk("jal_type", out_ty64, 4);

    send(32'h80000037, 64'h108, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_type", out_ty64, 3);

    send(32'h000FD073, 64'h10C, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("csr_imm", out_imm64, 64'h1F);
    chk("csr_type", out_ty64, 5);

    send(32'h0000007F, 64'h110, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("bad_type", out_ty64, 7);
    chk("bad_ill", out_ill64, 1);
    idle(1);
    chk("bad_cnt", cnt64, 1);

    // back-to-back into a stalled output
    send(32'h00500113, 64'hA1, 1'b0);
    send(32'h00600193, 64'hA2, 1'b0);
    @(negedge clk);
    in_instr = 32'h00700213; in_pc = 64'hA3;
    chk("full_ready", in_ready64, 0);
    chk("full_oldest", out_pc64, 64'hA1);
    @(negedge clk);
    out_ready = 1'b1;
    begin
      int n = 0;
      while (!in_ready64 && n < 20) begin @(negedge clk); n++; end
      chk("drain_ready", in_ready64, 1);
    end
    idle(4);
    chk("drain_empty", exp_q.size(), 0);

    // flush while full, with a discarded illegal transfer
    send(32'h00100093, 64'hB1, 1'b0);
    send(32'h00200093, 64'hB2, 1'b0);
    @(negedge clk);
    saved64 = cnt64;
    in_instr = 32'h0000007F; in_pc = 64'hB3; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vld", out_valid64, 0);
    chk("flush_rdy", in_ready64, 1);
    chk("flush_cnt", cnt64, saved64);
    idle(2);

    // asynchronous reset mid-stream
    send(32'h00100093, 64'hC1, 1'b0);
    send(32'h00200093, 64'hC2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    // saturation of the 2-bit counter
    for (int i = 0; i < 5; i++)
      send(32'h0000007F, 64'hD0 + 64'(i), 1'b1);
    idle(3);
    chk("sat_cnt64", cnt64, 3);
    chk("sat_cnt32", cnt32, 5);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = $urandom;
      if ($urandom_range(0, 3) != 0)
        in_instr[6:0] = ops[$urandom_range(0, 13)];
      in_pc = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 29) == 0);
    end
    idle(4);
    chk("final_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
